vcm_af_sweep_ctrl: RTL

Hill-climb autofocus sequencer that drives the VCM lens step. It sweeps the lens over a step range and writes each position to the VCM driver through a req/ack handshake. After each move it waits for the lens to settle, then captures the per-frame sharpness sum from the focus-statistics datapath. It records the peak, parks the lens at the best step, and reports done. It sits between the frame sharpness accumulator and the VCM serial writer.

---
 rtl/vcm_af_pkg.sv | 28 ++
 rtl/vcm_req_hold.sv | 39 +++
 rtl/vcm_af_sweep_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vcm_af_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vcm_af_pkg
// Brief    : Shared types, widths and VCM word formatting for the VCM
//            autofocus sweep controller.
// Revision : 1.0  initial release
// ============================================================================
package vcm_af_pkg;

    localparam int STEP_W  = 10;
    localparam int SHARP_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WRITE       = 3'd1,
        ST_SETTLE      = 3'd2,
        ST_MEASURE     = 3'd3,
        ST_FINAL_WRITE = 3'd4,
        ST_DONE        = 3'd5
    } af_state_t;

    // VCM driver word: two zero pad bits, lens step, four fixed mode bits.
    function automatic logic [15:0] vcm_word(input logic [STEP_W-1:0] step);
        return {2'b00, step, 4'b1111};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vcm_req_hold.sv
`default_nettype none
// ============================================================================
// Module   : vcm_req_hold
// Brief    : Single req/ack holding register for the VCM writer. Latches the
//            word when a write is launched and keeps req and data stable
//            until the writer acknowledges; req is never dropped early.
// Revision : 1.0  initial release
// ============================================================================
module vcm_req_hold
    import vcm_af_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [STEP_W-1:0] load_step,
    input  logic              ack,
    output logic              req,
    output logic [15:0]       data,
    output logic              accepted
);

    // An ack only counts while a request is outstanding.
    assign accepted = req & ack;

    // Request/data register: release on ack, otherwise launch on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req  <= 1'b0;
            data <= 16'h000F;
        end else if (accepted) begin
            req  <= 1'b0;
        end else if (load && !req) begin
            req  <= 1'b1;
            data <= vcm_word(load_step);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vcm_af_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vcm_af_sweep_ctrl
// Brief    : Hill-climb autofocus sequencer. Sweeps the VCM lens step,
//            waits for the lens to settle, measures frame sharpness, keeps
//            the peak and finally parks the lens at the best step.
// Revision : 1.0  initial release
// ============================================================================
module vcm_af_sweep_ctrl
    import vcm_af_pkg::*;
#(
    parameter int STEP_MIN      = 0,
    parameter int STEP_MAX      = 1023,
    parameter int STEP_INC      = 16,
    parameter int SETTLE_FRAMES = 2,
    parameter int EARLY_STOP    = 3
) (
    input  logic               VIDEO_CLK,
    input  logic               RESET_n,
    input  logic               AF_EN,
    input  logic               FRAME_END,
    input  logic [SHARP_W-1:0] SHARP,
    output logic               VCM_REQ,
    input  logic               VCM_ACK,
    output logic [15:0]        VCM_DATA,
    output logic [STEP_W-1:0]  STEP,
    output logic [STEP_W-1:0]  BEST_STEP,
    output logic [SHARP_W-1:0] PEAK,
    output logic               BUSY,
    output logic               DONE
);

    localparam int SET_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES + 1) : 1;
    localparam int BP_W  = (EARLY_STOP > 1) ? $clog2(EARLY_STOP + 1) : 1;

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'((SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0);
    localparam logic [BP_W-1:0]   BP_SAT      = '1;
    localparam logic [BP_W-1:0]   BP_LIMIT    = BP_W'(EARLY_STOP);
    localparam logic [STEP_W-1:0] FIRST_STEP  = STEP_W'(STEP_MIN);

    af_state_t          state;
    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  best_step;
    logic [SHARP_W-1:0] peak;
    logic [SET_W-1:0]   settle_cnt;
    logic [BP_W-1:0]    below_cnt;

    logic               wr_load;
    logic               wr_accepted;
    logic               better;
    logic [BP_W-1:0]    below_next;
    logic [STEP_W:0]    next_sum;
    logic               past_end;
    logic               early_hit;
    logic [STEP_W-1:0]  final_step;

    // A write is launched on the first cycle of either write state; the
    // holding register ignores load while a request is already pending.
    assign wr_load = AF_EN && ((state == ST_WRITE) || (state == ST_FINAL_WRITE));

    vcm_req_hold u_req_hold (
        .clk       (VIDEO_CLK),
        .rst_n     (RESET_n),
        .load      (wr_load),
        .load_step (step),
        .ack       (VCM_ACK),
        .req       (VCM_REQ),
        .data      (VCM_DATA),
        .accepted  (wr_accepted)
    );

    // Measurement decision; next step uses one extra bit so it cannot wrap.
    assign better     = SHARP > peak;
    assign below_next = better ? '0 : ((below_cnt == BP_SAT) ? below_cnt : below_cnt + BP_W'(1));
    assign next_sum   = {1'b0, step} + (STEP_W + 1)'(STEP_INC);
    assign past_end   = next_sum > (STEP_W + 1)'(STEP_MAX);
    assign early_hit  = (EARLY_STOP != 0) && (below_next == BP_LIMIT);
    // The final park step must include a peak found on this very frame.
    assign final_step = better ? step : best_step;

    assign STEP      = step;
    assign BEST_STEP = best_step;
    assign PEAK      = peak;
    assign BUSY      = (state != ST_IDLE) && (state != ST_DONE);
    assign DONE      = (state == ST_DONE);

    // Sweep sequencer.
    always_ff @(posedge VIDEO_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= ST_IDLE;
            step       <= FIRST_STEP;
            best_step  <= FIRST_STEP;
            peak       <= '0;
            settle_cnt <= '0;
            below_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (AF_EN) begin
                        state     <= ST_WRITE;
                        peak      <= '0;
                        step      <= FIRST_STEP;
                        best_step <= FIRST_STEP;
                        below_cnt <= '0;
                    end
                end

                ST_WRITE: begin
                    if (wr_accepted) begin
                        settle_cnt <= '0;
                        if (!AF_EN)
                            state <= ST_IDLE;
                        else if (SETTLE_FRAMES == 0)
                            state <= ST_MEASURE;
                        else
                            state <= ST_SETTLE;
                    end else if (!AF_EN && !VCM_REQ) begin
                        state <= ST_IDLE;
                    end
                end

                ST_SETTLE: begin
                    if (!AF_EN) begin
                        state <= ST_IDLE;
                    end else if (FRAME_END) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            settle_cnt <= '0;
                            state      <= ST_MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                end

                ST_MEASURE: begin
                    if (!AF_EN) begin
                        state <= ST_IDLE;
                    end else if (FRAME_END) begin
                        if (better) begin
                            peak      <= SHARP;
                            best_step <= step;
                        end
                        below_cnt <= below_next;
                        if (past_end || early_hit) begin
                            step  <= final_step;
                            state <= ST_FINAL_WRITE;
                        end else begin
                            step  <= next_sum[STEP_W-1:0];
                            state <= ST_WRITE;
                        end
                    end
                end

                ST_FINAL_WRITE: begin
                    if (wr_accepted)
                        state <= AF_EN ? ST_DONE : ST_IDLE;
                    else if (!AF_EN && !VCM_REQ)
                        state <= ST_IDLE;
                end

                ST_DONE: begin
                    if (!AF_EN)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
